// File: rtl/jt89_pkg.sv
// Shared constants for the JT89 host write sequencer: command types, FSM states
// and SN76489 latch-byte field values.
package jt89_pkg;

  localparam logic [1:0] CMD_TONE  = 2'd0;
  localparam logic [1:0] CMD_ATTN  = 2'd1;
  localparam logic [1:0] CMD_NOISE = 2'd2;
  localparam logic [1:0] CMD_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_GAP,
    ST_WAITRDY
  } state_t;

  localparam logic       LATCH_BIT = 1'b1;
  localparam logic       REG_TONE  = 1'b0;
  localparam logic       REG_ATTN  = 1'b1;
  localparam logic [1:0] NOISE_CH  = 2'b11;

endpackage

// File: rtl/jt89_wr_fmt.sv
// Combinational command formatter: {type, ch, data} -> latch byte, data byte and byte count.
module jt89_wr_fmt
  import jt89_pkg::*;
(
  input  logic [1:0] cmd_type,
  input  logic [1:0] cmd_ch,
  input  logic [9:0] cmd_data,
  output logic [7:0] b0,
  output logic [7:0] b1,
  output logic [1:0] nbytes
);

  always_comb begin
    b0     = 8'h00;
    b1     = 8'h00;
    nbytes = 2'd0;
    case (cmd_type)
      CMD_TONE: begin
        if (cmd_ch == NOISE_CH) begin
          // channel 3 has no period register; its tone command drives noise control
          b0     = {LATCH_BIT, NOISE_CH, REG_TONE, 1'b0, cmd_data[2:0]};
          nbytes = 2'd1;
        end else begin
          b0     = {LATCH_BIT, cmd_ch, REG_TONE, cmd_data[3:0]};
          b1     = {2'b00, cmd_data[9:4]};
          nbytes = 2'd2;
        end
      end
      CMD_ATTN: begin
        b0     = {LATCH_BIT, cmd_ch, REG_ATTN, cmd_data[3:0]};
        nbytes = 2'd1;
      end
      CMD_NOISE: begin
        b0     = {LATCH_BIT, NOISE_CH, REG_TONE, 1'b0, cmd_data[2:0]};
        nbytes = 2'd1;
      end
      default: nbytes = 2'd0;
    endcase
  end

endmodule

// File: rtl/jt89_wr_seq.sv
// Host-side JT89 write sequencer: serialises tone/attenuation/noise commands into
// paced wr_n byte writes. JT89_WR_SKIP_EN enables shadow-based redundant-write skipping.
//   state      | meaning
//   ST_IDLE    | ready for a command
//   ST_STROBE  | din valid; wr_n low for WR_LEN ticks after one setup tick
//   ST_GAP     | wr_n released, waiting GAP_LEN ticks
//   ST_WAITRDY | waiting for psg_ready (timeout after TMO ticks)
module jt89_wr_seq
  import jt89_pkg::*;
#(
  parameter int WR_LEN  = 2,
  parameter int GAP_LEN = 2,
  parameter int TMO     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [1:0] cmd_ch,
  input  logic [9:0] cmd_data,
  output logic [7:0] psg_din,
  output logic       psg_wr_n,
  input  logic       psg_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] WR_CNT  = 8'(WR_LEN);
  localparam logic [7:0] GAP_CNT = 8'(GAP_LEN - 1);
  localparam logic [7:0] TMO_CNT = 8'(TMO);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] din_q, din_d;
  logic [7:0] b1_q, b1_d;
  logic       wr_n_q, wr_n_d;
  logic       more_q, more_d;
  logic       err_q, err_d;

  logic [7:0] fmt_b0, fmt_b1;
  logic [1:0] fmt_nbytes;
  logic [1:0] n_issue;

  jt89_wr_fmt u_fmt (
    .cmd_type (cmd_type),
    .cmd_ch   (cmd_ch),
    .cmd_data (cmd_data),
    .b0       (fmt_b0),
    .b1       (fmt_b1),
    .nbytes   (fmt_nbytes)
  );

`ifdef JT89_WR_SKIP_EN
  logic [3:0][3:0] attn_sh_q, attn_sh_d;
  logic [3:0][9:0] per_sh_q, per_sh_d;
  logic [2:0]      noise_sh_q, noise_sh_d;
  logic [1:0]      kind_q, kind_d, ch_q, ch_d;
  logic            idx_q, idx_d;
  logic [1:0]      kind_in;
  logic            upd;

  always_comb begin
    kind_in = cmd_type;
    if (cmd_type == CMD_TONE && cmd_ch == NOISE_CH) kind_in = CMD_NOISE;
    n_issue = fmt_nbytes;
    case (kind_in)
      CMD_TONE: begin
        if (per_sh_q[cmd_ch] == cmd_data)                 n_issue = 2'd0;
        else if (per_sh_q[cmd_ch][9:4] == cmd_data[9:4])  n_issue = 2'd1;
        else                                              n_issue = 2'd2;
      end
      CMD_ATTN:  n_issue = (attn_sh_q[cmd_ch] == cmd_data[3:0]) ? 2'd0 : 2'd1;
      CMD_NOISE: n_issue = (noise_sh_q == cmd_data[2:0]) ? 2'd0 : 2'd1;
      default:   n_issue = 2'd0;
    endcase
  end

  assign upd = (state_q == ST_WAITRDY) && clk_en && psg_ready;

  // shadows follow bytes the chip has acknowledged, never the request
  always_comb begin
    attn_sh_d  = attn_sh_q;
    per_sh_d   = per_sh_q;
    noise_sh_d = noise_sh_q;
    kind_d     = kind_q;
    ch_d       = ch_q;
    idx_d      = idx_q;
    if (state_q == ST_IDLE && cmd_valid) begin
      kind_d = kind_in;
      ch_d   = cmd_ch;
      idx_d  = 1'b0;
    end
    if (upd) begin
      if (!idx_q) begin
        case (kind_q)
          CMD_ATTN:  attn_sh_d[ch_q] = din_q[3:0];
          CMD_NOISE: noise_sh_d = din_q[2:0];
          default:   per_sh_d[ch_q][3:0] = din_q[3:0];
        endcase
      end else begin
        per_sh_d[ch_q][9:4] = din_q[5:0];
      end
      if (more_q) idx_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      attn_sh_q  <= '1;
      per_sh_q   <= '0;
      noise_sh_q <= '0;
      kind_q     <= CMD_TONE;
      ch_q       <= 2'd0;
      idx_q      <= 1'b0;
    end else begin
      attn_sh_q  <= attn_sh_d;
      per_sh_q   <= per_sh_d;
      noise_sh_q <= noise_sh_d;
      kind_q     <= kind_d;
      ch_q       <= ch_d;
      idx_q      <= idx_d;
    end
  end
`else
  assign n_issue = fmt_nbytes;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    b1_d    = b1_q;
    wr_n_d  = wr_n_q;
    more_d  = more_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && n_issue != 2'd0) begin
          state_d = ST_STROBE;
          din_d   = fmt_b0;
          b1_d    = fmt_b1;
          more_d  = (n_issue == 2'd2);
          cnt_d   = WR_CNT;
          wr_n_d  = 1'b1;
        end
      end
      ST_STROBE: begin
        if (clk_en) begin
          if (cnt_q == 8'd0) begin
            state_d = ST_GAP;
            wr_n_d  = 1'b1;
            cnt_d   = GAP_CNT;
          end else begin
            wr_n_d = 1'b0;
            cnt_d  = cnt_q - 8'd1;
          end
        end
      end
      ST_GAP: begin
        if (clk_en) begin
          if (cnt_q == 8'd0) begin
            state_d = ST_WAITRDY;
            cnt_d   = TMO_CNT;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_WAITRDY: begin
        if (clk_en) begin
          if (psg_ready) begin
            if (more_q) begin
              state_d = ST_STROBE;
              din_d   = b1_q;
              more_d  = 1'b0;
              cnt_d   = WR_CNT;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = 8'd0;
            end
          end else if (cnt_q <= 8'd1) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            more_d  = 1'b0;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      din_q   <= 8'h00;
      b1_q    <= 8'h00;
      wr_n_q  <= 1'b1;
      more_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      b1_q    <= b1_d;
      wr_n_q  <= wr_n_d;
      more_q  <= more_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign psg_din   = din_q;
  assign psg_wr_n  = wr_n_q;
  assign err       = err_q;

endmodule
